// File: rtl/top_pkg.sv
// Shared definitions for the single-cycle MIPS-32 core.
// Holds the opcode/funct constants, the ALUOp and ALU-control encodings,
// the decoded control bundle and the active-low seven-segment table.
package top_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int DMEM_AW = 5;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } aluctl_e;

  typedef struct packed {
    logic   reg_dst;
    logic   alu_src;
    logic   mem_to_reg;
    logic   reg_write;
    logic   mem_read;
    logic   mem_write;
    logic   branch;
    logic   jump;
    aluop_e alu_op;
  } ctrl_t;

  // Active-low segments {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/top_if.sv
// Data-memory bus between the core datapath (master) and the data memory
// (slave). Byte address is only as wide as the 32-byte memory.
//   addr  : byte address of the word
//   wdata : store data, we : store strobe
//   rdata : load data, re : load strobe
interface top_if;
  import top_pkg::*;

  logic [DMEM_AW-1:0] addr;
  logic [DATA_W-1:0]  wdata;
  logic [DATA_W-1:0]  rdata;
  logic               we;
  logic               re;

  modport master (output addr, output wdata, output we, output re, input rdata);
  modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/top_alu.sv
// 32-bit ALU with wrapping arithmetic and signed set-less-than.
// Ports: a_i, b_i, ctl_i -> result_o, zero_o.
module top_alu
  import top_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [3:0]        ctl_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  logic signed [DATA_W-1:0] a_s, b_s;

  assign a_s = a_i;
  assign b_s = b_i;

  always_comb begin
    result_o = '0;
    case (ctl_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/top_aluctl.sv
// ALU control: ALUOp plus funct -> 4-bit ALU operation.
// Ports: aluop_i, funct_i, ctl_o.
module top_aluctl
  import top_pkg::*;
(
  input  aluop_e     aluop_i,
  input  logic [5:0] funct_i,
  output logic [3:0] ctl_o
);

  always_comb begin
    ctl_o = ALU_ADD;
    case (aluop_i)
      ALUOP_SUB: ctl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_SUB:  ctl_o = ALU_SUB;
          FN_AND:  ctl_o = ALU_AND;
          FN_OR:   ctl_o = ALU_OR;
          FN_SLT:  ctl_o = ALU_SLT;
          default: ctl_o = ALU_ADD;
        endcase
      end
      default: ctl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/top_control.sv
// Main decoder: opcode -> control bundle. Unknown opcodes decode to all
// zeros, which gives PC+4 with no register or memory write.
// Ports: opcode_i, ctrl_o.
module top_control
  import top_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o        = '0;
    ctrl_o.alu_op = ALUOP_ADD;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      OP_ADDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_read   = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALUOP_SUB;
      end
      OP_J:    ctrl_o.jump = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/top_dmem.sv
// 32-byte little-endian data memory: word at A = {Dmem[A+3] .. Dmem[A]}.
// Synchronous word store, combinational word load, asynchronous clear.
// Ports: clk, rst_n, bus (slave side of top_if).
module top_dmem
  import top_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  top_if.slave  bus
);

  logic [7:0] Dmem [0:31];
  logic [DMEM_AW-1:0] a0, a1, a2, a3;

  // Byte lanes wrap inside the 32-byte array
  assign a0 = bus.addr;
  assign a1 = bus.addr + 5'd1;
  assign a2 = bus.addr + 5'd2;
  assign a3 = bus.addr + 5'd3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) Dmem[i] <= '0;
    end else if (bus.we) begin
      Dmem[a0] <= bus.wdata[7:0];
      Dmem[a1] <= bus.wdata[15:8];
      Dmem[a2] <= bus.wdata[23:16];
      Dmem[a3] <= bus.wdata[31:24];
    end
  end

  assign bus.rdata = bus.re ? {Dmem[a3], Dmem[a2], Dmem[a1], Dmem[a0]} : '0;

endmodule

// File: rtl/top_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous
// write port. R0 always reads zero. Asynchronous active-low clear.
// Ports: clk, rst_n, we_i/waddr_i/wdata_i (write), raddr1_i/raddr2_i ->
// rdata1_o/rdata2_o (reads), r17_o (R17 tap for the display).
module top_regfile
  import top_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [DATA_W-1:0] r17_o
);

  logic [DATA_W-1:0] RegData [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) RegData[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      RegData[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = RegData[raddr1_i];
  assign rdata2_o = RegData[raddr2_i];
  assign r17_o    = RegData[17];

endmodule

// File: rtl/top_rom.sv
// Hard-coded instruction ROM (64 words, word-addressed by PC[7:2]).
// Program: Fibonacci loop leaving F(10)=55 in R17, stores it to memory
// word 0, reloads it into R18, then spins on a beq-to-self.
// Ports: addr_i (word index), instr_o.
module top_rom
  import top_pkg::*;
(
  input  logic [5:0]        addr_i,
  output logic [DATA_W-1:0] instr_o
);

  always_comb begin
    case (addr_i)
      6'd0:    instr_o = 32'h2010000A; // addi s0,zero,10
      6'd1:    instr_o = 32'h20080000; // addi t0,zero,0
      6'd2:    instr_o = 32'h20090001; // addi t1,zero,1
      6'd3:    instr_o = 32'h200A0000; // addi t2,zero,0
      6'd4:    instr_o = 32'h11500005; // beq  t2,s0,+5
      6'd5:    instr_o = 32'h01095820; // add  t3,t0,t1
      6'd6:    instr_o = 32'h01204020; // add  t0,t1,zero
      6'd7:    instr_o = 32'h01604820; // add  t1,t3,zero
      6'd8:    instr_o = 32'h214A0001; // addi t2,t2,1
      6'd9:    instr_o = 32'h08000004; // j    0x10
      6'd10:   instr_o = 32'h01008820; // add  s1,t0,zero
      6'd11:   instr_o = 32'hAC110000; // sw   s1,0(zero)
      6'd12:   instr_o = 32'h8C120000; // lw   s2,0(zero)
      6'd13:   instr_o = 32'h1000FFFF; // beq  zero,zero,-1
      default: instr_o = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/top_seg7.sv
// BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Non-decimal codes blank the digit.
// Ports: bcd_i, seg_o.
module top_seg7
  import top_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/top.sv
// Single-cycle MIPS-32 core with hard-coded program and a five-digit
// seven-segment readout of R17 (decimal, modulo 100000).
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset (PC, registers, memory)
//   seg_first  : ones digit of R17 ... seg_fifth : ten-thousands digit
module top
  import top_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [6:0] seg_first,
  output logic [6:0] seg_second,
  output logic [6:0] seg_third,
  output logic [6:0] seg_fourth,
  output logic [6:0] seg_fifth
);

  logic [DATA_W-1:0] pc_q, pc_d, pc_in, pc_plus4;
  logic [DATA_W-1:0] im_instruction;
  logic [DATA_W-1:0] r_read1, r_read2, r_wbdata, r17;
  logic [DATA_W-1:0] imm_ext, alu_b, alu_result;
  logic [DATA_W-1:0] br_target, j_target;
  logic [REG_AW-1:0] wr_addr;
  logic [3:0]        c_ALUcontrol;
  logic [1:0]        c_ALUOp;
  logic              c_MemRead, c_MemWrite;
  logic              alu_zero;
  logic [19:0]       bcd;
  ctrl_t             ctrl;

  top_if dbus ();

  // Binary to packed BCD by shift-and-add-3. Only five digits are kept;
  // carries never flow downward, so the dropped upper digits just remove
  // multiples of 100000.
  function automatic logic [19:0] bin2bcd5(input logic [DATA_W-1:0] bin);
    logic [19:0] acc;
    acc = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      for (int d = 0; d < 5; d++) begin
        if (acc[d*4 +: 4] >= 4'd5) acc[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
      end
      acc = {acc[18:0], bin[i]};
    end
    return acc;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc_in = pc_q;

  top_rom u_Rom (
    .addr_i  (pc_in[7:2]),
    .instr_o (im_instruction)
  );

  top_control u_Control (
    .opcode_i (im_instruction[31:26]),
    .ctrl_o   (ctrl)
  );

  assign c_ALUOp    = ctrl.alu_op;
  assign c_MemRead  = ctrl.mem_read;
  assign c_MemWrite = ctrl.mem_write;

  top_aluctl u_ALUcontrol (
    .aluop_i (ctrl.alu_op),
    .funct_i (im_instruction[5:0]),
    .ctl_o   (c_ALUcontrol)
  );

  assign wr_addr = ctrl.reg_dst ? im_instruction[15:11] : im_instruction[20:16];

  top_regfile u_Register (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (ctrl.reg_write),
    .waddr_i  (wr_addr),
    .wdata_i  (r_wbdata),
    .raddr1_i (im_instruction[25:21]),
    .raddr2_i (im_instruction[20:16]),
    .rdata1_o (r_read1),
    .rdata2_o (r_read2),
    .r17_o    (r17)
  );

  assign imm_ext = {{16{im_instruction[15]}}, im_instruction[15:0]};
  assign alu_b   = ctrl.alu_src ? imm_ext : r_read2;

  top_alu u_ALU (
    .a_i      (r_read1),
    .b_i      (alu_b),
    .ctl_i    (c_ALUcontrol),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  assign dbus.addr  = alu_result[DMEM_AW-1:0];
  assign dbus.wdata = r_read2;
  assign dbus.we    = ctrl.mem_write;
  assign dbus.re    = ctrl.mem_read;

  top_dmem u_Data_memory (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dbus.slave)
  );

  assign r_wbdata = ctrl.mem_to_reg ? dbus.rdata : alu_result;

  // Next PC: jump wins over a taken branch; both are exclusive by opcode
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{14{im_instruction[15]}}, im_instruction[15:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], im_instruction[25:0], 2'b00};

  always_comb begin
    pc_d = pc_plus4;
    if (ctrl.jump)                   pc_d = j_target;
    else if (ctrl.branch && alu_zero) pc_d = br_target;
  end

  assign bcd = bin2bcd5(r17);

  top_seg7 u_Seg0 (.bcd_i(bcd[3:0]),   .seg_o(seg_first));
  top_seg7 u_Seg1 (.bcd_i(bcd[7:4]),   .seg_o(seg_second));
  top_seg7 u_Seg2 (.bcd_i(bcd[11:8]),  .seg_o(seg_third));
  top_seg7 u_Seg3 (.bcd_i(bcd[15:12]), .seg_o(seg_fourth));
  top_seg7 u_Seg4 (.bcd_i(bcd[19:16]), .seg_o(seg_fifth));

endmodule

// File: tb/tb_top.sv
// Directed bench for the single-cycle core: reset state, first
// instruction, full program run with end-state table, sw/lw cycle control
// signals, asynchronous reset from the halted state and mid-program.
module tb_top;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_first, seg_second, seg_third, seg_fourth, seg_fifth;

  int n_tests = 0;
  int n_fail  = 0;

  top dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_first  (seg_first),
    .seg_second (seg_second),
    .seg_third  (seg_third),
    .seg_fourth (seg_fourth),
    .seg_fifth  (seg_fifth)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  localparam int K_REG = 0;
  localparam int K_MEM = 1;
  localparam int K_SEG = 2;
  localparam int K_PC  = 3;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {dut.u_Data_memory.Dmem[a+3], dut.u_Data_memory.Dmem[a+2],
            dut.u_Data_memory.Dmem[a+1], dut.u_Data_memory.Dmem[a]};
  endfunction

  function automatic logic [31:0] probe(input int kind, input int idx);
    logic [31:0] v;
    v = '0;
    case (kind)
      K_REG: v = dut.u_Register.RegData[idx];
      K_MEM: v = mem_word(idx);
      K_SEG: begin
        case (idx)
          0: v = {25'd0, seg_first};
          1: v = {25'd0, seg_second};
          2: v = {25'd0, seg_third};
          3: v = {25'd0, seg_fourth};
          default: v = {25'd0, seg_fifth};
        endcase
      end
      default: v = dut.pc_in;
    endcase
    return v;
  endfunction

  // Runs until PC reaches the halt loop (bounded); returns cycles taken.
  task automatic run_to_halt(input int start_cyc, output int cyc, input bit watch_mem);
    bit saw_sw, saw_lw;
    saw_sw = 1'b0;
    saw_lw = 1'b0;
    cyc = start_cyc;
    while (dut.pc_in !== 32'h34 && cyc < 120) begin
      step();
      cyc++;
      if (watch_mem && dut.im_instruction === 32'hAC110000) begin
        saw_sw = 1'b1;
        chk("sw_MemWrite", {31'd0, dut.c_MemWrite}, 32'd1);
        chk("sw_MemRead", {31'd0, dut.c_MemRead}, 32'd0);
      end
      if (watch_mem && dut.im_instruction === 32'h8C120000) begin
        saw_lw = 1'b1;
        chk("lw_MemRead", {31'd0, dut.c_MemRead}, 32'd1);
        chk("lw_wbdata", dut.r_wbdata, 32'h37);
      end
    end
    if (watch_mem) begin
      chk("sw_cycle_seen", {31'd0, saw_sw}, 32'd1);
      chk("lw_cycle_seen", {31'd0, saw_lw}, 32'd1);
    end
  endtask

  initial begin
    int cyc;

    vecs[0]  = '{"R16",      K_REG, 16, 32'h0000000A};
    vecs[1]  = '{"R17",      K_REG, 17, 32'h00000037};
    vecs[2]  = '{"R8",       K_REG, 8,  32'h00000037};
    vecs[3]  = '{"R9",       K_REG, 9,  32'h00000059};
    vecs[4]  = '{"R10",      K_REG, 10, 32'h0000000A};
    vecs[5]  = '{"R11",      K_REG, 11, 32'h00000059};
    vecs[6]  = '{"R18",      K_REG, 18, 32'h00000037};
    vecs[7]  = '{"R0",       K_REG, 0,  32'h00000000};
    vecs[8]  = '{"mem_w00",  K_MEM, 0,  32'h00000037};
    vecs[9]  = '{"mem_w04",  K_MEM, 4,  32'h00000000};
    vecs[10] = '{"mem_w08",  K_MEM, 8,  32'h00000000};
    vecs[11] = '{"mem_w0C",  K_MEM, 12, 32'h00000000};
    vecs[12] = '{"mem_w10",  K_MEM, 16, 32'h00000000};
    vecs[13] = '{"mem_w14",  K_MEM, 20, 32'h00000000};
    vecs[14] = '{"mem_w18",  K_MEM, 24, 32'h00000000};
    vecs[15] = '{"mem_w1C",  K_MEM, 28, 32'h00000000};
    vecs[16] = '{"seg_1st",  K_SEG, 0,  32'h00000012};
    vecs[17] = '{"seg_2nd",  K_SEG, 1,  32'h00000012};
    vecs[18] = '{"seg_3rd",  K_SEG, 2,  32'h00000040};
    vecs[19] = '{"seg_4th",  K_SEG, 3,  32'h00000040};
    vecs[20] = '{"seg_5th",  K_SEG, 4,  32'h00000040};
    vecs[21] = '{"pc_end",   K_PC,  0,  32'h00000034};
    vecs[22] = '{"R1",       K_REG, 1,  32'h00000000};
    vecs[23] = '{"R19",      K_REG, 19, 32'h00000000};

    // Reset state
    rst_n = 1'b0;
    #35;
    chk("rst_pc", dut.pc_in, 32'h0);
    chk("rst_R16", probe(K_REG, 16), 32'h0);
    for (int s = 0; s < 5; s++) chk("rst_seg", probe(K_SEG, s), 32'h40);

    // First instruction
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("first_pc", dut.pc_in, 32'h04);
    chk("first_R16", probe(K_REG, 16), 32'h0A);
    chk("first_ALUOp", {30'd0, dut.c_ALUOp}, 32'd0);

    // Full program
    run_to_halt(1, cyc, 1'b1);
    chk("halt_pc", dut.pc_in, 32'h34);
    chk("halt_in_75", {31'd0, (cyc <= 75)}, 32'd1);
    chk("halt_ALUOp", {30'd0, dut.c_ALUOp}, 32'd1);
    chk("halt_ALUctl", {28'd0, dut.c_ALUcontrol}, 32'h6);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("pc_stable", dut.pc_in, 32'h34);
    end

    for (int v = 0; v < 24; v++)
      chk(vecs[v].name, probe(vecs[v].kind, vecs[v].idx), vecs[v].exp);

    // Asynchronous reset from the halted state, checked before any edge
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", dut.pc_in, 32'h0);
    chk("arst_R17", probe(K_REG, 17), 32'h0);
    chk("arst_R9", probe(K_REG, 9), 32'h0);
    chk("arst_mem0", probe(K_MEM, 0), 32'h0);
    chk("arst_seg1", probe(K_SEG, 0), 32'h40);
    chk("arst_seg2", probe(K_SEG, 1), 32'h40);

    // Reset in the middle of the loop, then a full rerun
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) step();
    chk("mid_R9_live", {31'd0, (probe(K_REG, 9) != 32'h0)}, 32'd1);
    #4;
    rst_n = 1'b0;
    #1;
    chk("mid_pc", dut.pc_in, 32'h0);
    chk("mid_R9", probe(K_REG, 9), 32'h0);
    chk("mid_R16", probe(K_REG, 16), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_to_halt(0, cyc, 1'b0);
    chk("rerun_pc", dut.pc_in, 32'h34);
    chk("rerun_R17", probe(K_REG, 17), 32'h37);
    chk("rerun_R16", probe(K_REG, 16), 32'h0A);
    chk("rerun_mem0", probe(K_MEM, 0), 32'h37);
    chk("rerun_seg1", probe(K_SEG, 0), 32'h12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port `seg_first`, output, 7 bits: active-low segments {g,f,e,d,c,b,a}, decimal ones digit of R17.
REQ-004 SHALL have port `seg_second`, output, 7 bits: same encoding, tens digit of R17.
REQ-005 SHALL have port `seg_third`, output, 7 bits: same encoding, hundreds digit of R17.
REQ-006 SHALL have port `seg_fourth`, output, 7 bits: same encoding, thousands digit of R17.
REQ-007 SHALL have port `seg_fifth`, output, 7 bits: same encoding, ten-thousands digit of R17 (R17 mod 100000).
REQ-008 SHALL expose hierarchical nets `pc_in`, `im_instruction`, `c_ALUcontrol`[3:0], `c_ALUOp`[1:0], `alu_result`, `r_read1`, `r_read2`, `r_wbdata`, `c_MemRead`, `c_MemWrite` at top level.
REQ-009 SHALL have the register-file instance named `u_Register`, array `RegData[0:31]`, 32-bit entries.
REQ-010 SHALL have the data-memory instance named `u_Data_memory`, array `Dmem[0:31]` of bytes, little-endian: word at A = {Dmem[A+3..A]}.

Function
REQ-011 SHALL be a single-cycle MIPS-32 core: fetch, decode, execute, memory and writeback complete in one clock; PC advances every rising edge.
REQ-012 SHALL support add, sub, and, or, slt (R-type), addi, lw, sw, beq, j; other opcodes SHALL execute as NOP (PC+4, no writes).
REQ-013 SHALL generate ALUOp as 00=add (lw/sw/addi), 01=sub (beq), 10=funct-decoded; ALUcontrol as 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
REQ-014 SHALL hold R0 at 0; writes to R0 SHALL be ignored.
REQ-015 SHALL make register and memory writes synchronous; register and memory reads combinational.
REQ-016 SHALL compute beq target as PC+4+(sext(imm)<<2), and j target as {PC+4[31:28], addr26, 00}.
REQ-017 SHALL sign-extend the 16-bit immediate; 32-bit arithmetic SHALL wrap, with no overflow traps.
REQ-018 SHALL use a hard-coded instruction ROM, word-addressed by PC[7:2], holding exactly:
  0x00 addi s0,0,10; 0x04 addi t0,0,0; 0x08 addi t1,0,1; 0x0C addi t2,0,0;
  0x10 beq t2,s0,+5; 0x14 add t3,t0,t1; 0x18 add t0,t1,0; 0x1C add t1,t3,0;
  0x20 addi t2,t2,1; 0x24 j 0x10; 0x28 add s1,t0,0; 0x2C sw s1,0(0);
  0x30 lw s2,0(0); 0x34 beq 0,0,-1 (halt loop); remaining ROM words SHALL be 0 (NOP).
REQ-019 SHALL reach the halt loop within 75 cycles after reset release, ending with R16=10 and R17=55.
REQ-020 SHALL generate the seven-segment outputs combinationally from R17 via binary-to-BCD conversion and an active-low decoder: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.

Reset
REQ-021 SHALL, on rst_n low, immediately set PC=0 and clear all 32 registers and all 32 memory bytes to 0, independent of clk.
REQ-022 SHALL make all seg outputs 0x40 while in reset; execution SHALL restart at 0x00 on the first rising edge after rst_n rises.
REQ-023 SHALL, if reset is asserted mid-program, abandon the program state; after release the run SHALL recompute the identical final result.

Structure
REQ-024 SHALL place opcode/funct constants, ALUOp and ALUcontrol encodings and the segment table in a shared package.
REQ-025 SHALL use sub-modules for the register file (`u_Register`), data memory (`u_Data_memory`), control, ALU control, ALU, instruction ROM and BCD-to-seven-segment decoder; the decoder SHALL be the sole reusable sub-module, instantiated 5 times.

Verification
REQ-026 SHALL pass: reset, then 1 cycle -> PC=0x04, R16=0x0000000A.
REQ-027 SHALL pass: run 1800 ns at a 20 ns clock -> R16=10, R17=0x37, R8=0x37, R9=0x59, R10=0x0A, R11=0x59, R18=0x37.
REQ-028 SHALL pass: at end of run -> data-memory word 0x00=0x00000037, words 0x04..0x1C=0.
REQ-029 SHALL pass: at end of run -> seg_first=0x12, seg_second=0x12, seg_third/fourth/fifth=0x40, PC stable at 0x34.
REQ-030 SHALL pass: at the sw cycle -> c_MemWrite=1 and c_MemRead=0; at the lw cycle -> c_MemRead=1 and r_wbdata=0x37.
REQ-031 SHALL pass: rst_n pulsed low at 500 ns -> PC, registers and memory 0 asynchronously; rerun ends with R17=55.
